// File: rtl/camera_pkg.sv
// ============================================================================
// Module      : camera_pkg
// Description : Shared frame-buffer geometry, capture FSM encoding and
//               RGB332 field layout for the camera / VGA painter pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package camera_pkg;

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_CAPTURE    = 2'd2
    } cap_state_t;

    localparam int RGB332_R_MSB = 7;
    localparam int RGB332_R_LSB = 5;
    localparam int RGB332_G_MSB = 4;
    localparam int RGB332_G_LSB = 2;
    localparam int RGB332_B_MSB = 1;
    localparam int RGB332_B_LSB = 0;

    // b1 = RRRRRGGG, b2 = GGGBBBBB; keep the top bits of each channel.
    function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] i_b1,
                                                    input logic [7:0] i_b2);
        return {i_b1[7:5], i_b1[2:0], i_b2[4:3]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cam_input_sync.sv
// ============================================================================
// Module      : cam_input_sync
// Description : Multi-stage synchroniser for the camera bus plus edge
//               detection of pclk/vsync/href; data stays aligned to pclk.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_input_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pclk,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_pclk_rise,
    output logic              o_vsync_rise,
    output logic              o_vsync_fall,
    output logic              o_href_fall,
    output logic              o_href,
    output logic [DATA_W-1:0] o_data
);

    localparam int C_BUS_W = DATA_W + 3;

    logic [C_BUS_W-1:0] r_sync [SYNC_STAGES];
    logic [2:0]         r_prev;
    logic               w_pclk;
    logic               w_vsync;
    logic               w_href;

    // Data travels through the same chain as pclk, so it is valid on pclk_rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= {i_pclk, i_vsync, i_href, i_data};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= {w_pclk, w_vsync, w_href};
        end
    end

    assign {w_pclk, w_vsync, w_href, o_data} = r_sync[SYNC_STAGES-1];

    assign o_pclk_rise  = w_pclk  & ~r_prev[2];
    assign o_vsync_rise = w_vsync & ~r_prev[1];
    assign o_vsync_fall = ~w_vsync & r_prev[1];
    assign o_href_fall  = ~w_href & r_prev[0];
    assign o_href       = w_href;

endmodule

`default_nettype wire

// File: rtl/ov7670_capture.sv
// ============================================================================
// Module      : ov7670_capture
// Description : OV7670 RGB565 stream to 4x-decimated RGB332 frame-buffer
//               writer (pairing, conversion, counters, capture FSM).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ov7670_capture
    import camera_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int DECIM_LOG2  = 2,
    parameter int ADDR_W      = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk50,
    input  logic              rst,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              capture_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              overflow
);

    localparam logic [9:0]  C_X_LIMIT  = 10'(H_ACTIVE);
    localparam logic [8:0]  C_Y_LIMIT  = 9'(V_ACTIVE);
    localparam logic [14:0] C_ADDR_MAX =
        15'((H_ACTIVE >> DECIM_LOG2) * (V_ACTIVE >> DECIM_LOG2) - 1);

    logic       w_pclk_rise;
    logic       w_vsync_rise;
    logic       w_vsync_fall;
    logic       w_href_fall;
    logic       w_href;
    logic [7:0] w_data;
    logic       w_wr_cond;

    cap_state_t  r_state;
    logic        r_phase;
    logic [7:0]  r_b1;
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [14:0] r_addr;
    logic        r_wr_req;
    logic [7:0]  r_pix;

    cam_input_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .DATA_W      (8)
    ) u_sync (
        .clk          (clk50),
        .rst_n        (rst),
        .i_pclk       (cam_pclk),
        .i_vsync      (cam_vsync),
        .i_href       (cam_href),
        .i_data       (cam_data),
        .o_pclk_rise  (w_pclk_rise),
        .o_vsync_rise (w_vsync_rise),
        .o_vsync_fall (w_vsync_fall),
        .o_href_fall  (w_href_fall),
        .o_href       (w_href),
        .o_data       (w_data)
    );

    assign w_wr_cond = (r_x[DECIM_LOG2-1:0] == '0) && (r_y[DECIM_LOG2-1:0] == '0)
                    && (r_x < C_X_LIMIT) && (r_y < C_Y_LIMIT);

    always_ff @(posedge clk50 or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_phase    <= 1'b0;
            r_b1       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_addr     <= '0;
            r_wr_req   <= 1'b0;
            r_pix      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            r_wr_req   <= 1'b0;

            // Second pipeline stage: commit the pixel unless the buffer is full.
            if (r_wr_req) begin
                if (r_addr > C_ADDR_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    wr_en   <= 1'b1;
                    wr_addr <= ADDR_W'(r_addr);
                    wr_data <= r_pix;
                    r_addr  <= r_addr + 15'd1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_WAIT_FRAME;
                end
                ST_WAIT_FRAME: begin
                    if (w_vsync_fall && capture_en) begin
                        r_state  <= ST_CAPTURE;
                        r_addr   <= '0;
                        r_x      <= '0;
                        r_y      <= '0;
                        r_phase  <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (w_vsync_rise) begin
                        frame_done <= 1'b1;
                        r_state    <= ST_WAIT_FRAME;
                    end else if (w_pclk_rise && w_href) begin
                        r_phase <= ~r_phase;
                        if (!r_phase) begin
                            r_b1 <= w_data;
                        end else begin
                            r_wr_req <= w_wr_cond;
                            r_pix    <= rgb565_to_rgb332(r_b1, w_data);
                            r_x      <= (r_x == '1) ? r_x : r_x + 10'd1;
                        end
                    end else if (w_href_fall) begin
                        r_phase <= 1'b0;
                        r_x     <= '0;
                        r_y     <= (r_y == '1) ? r_y : r_y + 9'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
